// File: rtl/issue_scoreboard.sv
// In-order-issue / out-of-order-completion scoreboard with a circular entry buffer,
// multi-port writeback, head-of-queue commit and two-operand forwarding lookup.
module issue_scoreboard #(
    parameter  int NR_ENTRIES    = 8,
    parameter  int NR_WB_PORTS   = 3,
    localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   issue_valid_i,
    output logic                                   issue_ready_o,
    input  logic [63:0]                            issue_pc_i,
    input  logic [3:0]                             issue_fu_i,
    input  logic [4:0]                             issue_rd_i,
    output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
    input  logic [NR_WB_PORTS*64-1:0]              wb_result_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_ex_valid_i,
    input  logic [NR_WB_PORTS*64-1:0]              wb_ex_cause_i,
    output logic                                   commit_valid_o,
    input  logic                                   commit_ack_i,
    output logic [TRANS_ID_BITS-1:0]               commit_trans_id_o,
    output logic [63:0]                            commit_pc_o,
    output logic [4:0]                             commit_rd_o,
    output logic [63:0]                            commit_result_o,
    output logic                                   commit_ex_valid_o,
    output logic [63:0]                            commit_ex_cause_o,
    input  logic [4:0]                             rs1_i,
    input  logic [4:0]                             rs2_i,
    output logic                                   rs1_busy_o,
    output logic                                   rs2_busy_o,
    output logic                                   rs1_fwd_valid_o,
    output logic                                   rs2_fwd_valid_o,
    output logic [63:0]                            rs1_fwd_o,
    output logic [63:0]                            rs2_fwd_o,
    output logic [TRANS_ID_BITS:0]                 count_o
);

    localparam logic [3:0]           FU_NONE = 4'd0;
    localparam logic [TRANS_ID_BITS:0] FULL  = (TRANS_ID_BITS+1)'(NR_ENTRIES);

    // The target unit only decides whether a writeback is expected; nothing
    // downstream reads it, so only its effect (done at issue) is kept.
    logic        busy     [NR_ENTRIES];
    logic        done     [NR_ENTRIES];
    logic [63:0] pc       [NR_ENTRIES];
    logic [4:0]  rd       [NR_ENTRIES];
    logic [63:0] result   [NR_ENTRIES];
    logic        ex_valid [NR_ENTRIES];
    logic [63:0] ex_cause [NR_ENTRIES];

    logic [TRANS_ID_BITS-1:0] head;
    logic [TRANS_ID_BITS-1:0] tail;
    logic [TRANS_ID_BITS:0]   count;

    logic accept;
    logic retire;

    assign issue_ready_o    = (count < FULL);
    assign issue_trans_id_o = tail;
    assign count_o          = count;

    assign commit_valid_o    = busy[head] && done[head];
    assign commit_trans_id_o = head;
    assign commit_pc_o       = pc[head];
    assign commit_rd_o       = rd[head];
    assign commit_result_o   = result[head];
    assign commit_ex_valid_o = ex_valid[head];
    assign commit_ex_cause_o = ex_cause[head];

    assign accept = issue_valid_i && issue_ready_o && !flush_i;
    assign retire = commit_ack_i && commit_valid_o && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                busy[i]     <= 1'b0;
                done[i]     <= 1'b0;
                pc[i]       <= '0;
                rd[i]       <= '0;
                result[i]   <= '0;
                ex_valid[i] <= 1'b0;
                ex_cause[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                busy[i] <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Ports are visited in ascending order so the last non-blocking
            // write, i.e. the highest port index, wins on an ID collision.
            for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && busy[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]) begin
                    done[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]     <= 1'b1;
                    result[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]   <= wb_result_i[p*64 +: 64];
                    ex_valid[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]] <= wb_ex_valid_i[p];
                    ex_cause[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]] <= wb_ex_cause_i[p*64 +: 64];
                end
            end

            if (retire) begin
                busy[head] <= 1'b0;
                head       <= head + 1'b1;
            end

            if (accept) begin
                busy[tail]     <= 1'b1;
                done[tail]     <= (issue_fu_i == FU_NONE);
                pc[tail]       <= issue_pc_i;
                rd[tail]       <= issue_rd_i;
                result[tail]   <= '0;
                ex_valid[tail] <= 1'b0;
                ex_cause[tail] <= '0;
                tail           <= tail + 1'b1;
            end

            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic [4:0]  lk_rs        [2];
    logic        lk_busy      [2];
    logic        lk_fwd_valid [2];
    logic [63:0] lk_fwd       [2];

    assign lk_rs[0] = rs1_i;
    assign lk_rs[1] = rs2_i;

    // Scan oldest to youngest from head; the last busy match is the youngest producer.
    always_comb begin
        logic                     hit;
        logic [TRANS_ID_BITS-1:0] sel;
        logic [TRANS_ID_BITS-1:0] idx;
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            lk_busy[s]      = 1'b0;
            lk_fwd_valid[s] = 1'b0;
            lk_fwd[s]       = '0;
            hit             = 1'b0;
            sel             = '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                idx = head + TRANS_ID_BITS'(i);
                if (busy[idx] && rd[idx] == lk_rs[s]) begin
                    hit = 1'b1;
                    sel = idx;
                end
            end
            if (hit && lk_rs[s] != 5'd0) begin
                if (!done[sel]) begin
                    lk_busy[s] = 1'b1;
                end else if (!ex_valid[sel]) begin
                    lk_fwd_valid[s] = 1'b1;
                    lk_fwd[s]       = result[sel];
                end
            end
        end
    end

    assign rs1_busy_o      = lk_busy[0];
    assign rs2_busy_o      = lk_busy[1];
    assign rs1_fwd_valid_o = lk_fwd_valid[0];
    assign rs2_fwd_valid_o = lk_fwd_valid[1];
    assign rs1_fwd_o       = lk_fwd[0];
    assign rs2_fwd_o       = lk_fwd[1];

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard with a 4-entry, 3-port instance.
module tb_issue_scoreboard;

    localparam int N   = 4;
    localparam int P   = 3;
    localparam int TID = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            issue_valid;
    logic            issue_ready;
    logic [63:0]     issue_pc;
    logic [3:0]      issue_fu;
    logic [4:0]      issue_rd;
    logic [TID-1:0]  issue_trans_id;
    logic [P-1:0]    wb_valid;
    logic [P*TID-1:0] wb_trans_id;
    logic [P*64-1:0] wb_result;
    logic [P-1:0]    wb_ex_valid;
    logic [P*64-1:0] wb_ex_cause;
    logic            commit_valid;
    logic            commit_ack;
    logic [TID-1:0]  commit_trans_id;
    logic [63:0]     commit_pc;
    logic [4:0]      commit_rd;
    logic [63:0]     commit_result;
    logic            commit_ex_valid;
    logic [63:0]     commit_ex_cause;
    logic [4:0]      rs1, rs2;
    logic            rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
    logic [63:0]     rs1_fwd, rs2_fwd;
    logic [TID:0]    count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_pc_i(issue_pc),
        .issue_fu_i(issue_fu), .issue_rd_i(issue_rd), .issue_trans_id_o(issue_trans_id),
        .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
        .wb_ex_valid_i(wb_ex_valid), .wb_ex_cause_i(wb_ex_cause),
        .commit_valid_o(commit_valid), .commit_ack_i(commit_ack),
        .commit_trans_id_o(commit_trans_id), .commit_pc_o(commit_pc), .commit_rd_o(commit_rd),
        .commit_result_o(commit_result), .commit_ex_valid_o(commit_ex_valid),
        .commit_ex_cause_o(commit_ex_cause),
        .rs1_i(rs1), .rs2_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .rs1_fwd_valid_o(rs1_fwd_valid), .rs2_fwd_valid_o(rs2_fwd_valid),
        .rs1_fwd_o(rs1_fwd), .rs2_fwd_o(rs2_fwd), .count_o(count)
    );

    task automatic clear_pulses();
        flush = 0; issue_valid = 0; commit_ack = 0;
        wb_valid = '0; wb_ex_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic do_reset();
        clear_pulses();
        issue_pc = '0; issue_fu = 4'd1; issue_rd = '0;
        wb_trans_id = '0; wb_result = '0; wb_ex_cause = '0;
        rs1 = '0; rs2 = '0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic set_issue(input logic [3:0] fu, input logic [4:0] rd, input logic [63:0] pc);
        issue_valid = 1; issue_fu = fu; issue_rd = rd; issue_pc = pc;
    endtask

    task automatic set_wb(input int p, input logic [TID-1:0] id, input logic [63:0] res,
                          input logic ex, input logic [63:0] cause);
        wb_valid[p] = 1'b1;
        wb_trans_id[p*TID +: TID] = id;
        wb_result[p*64 +: 64] = res;
        wb_ex_valid[p] = ex;
        wb_ex_cause[p*64 +: 64] = cause;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) tick();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", issue_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %0b want 0", commit_valid); end
        checks++; if (issue_trans_id !== 2'd0) begin errors++; $display("FAIL reset_trans_id: got %0d want 0", issue_trans_id); end
        checks++; if (commit_result !== 64'd0 || commit_pc !== 64'd0) begin errors++; $display("FAIL reset_commit_data: got %0h/%0h want 0/0", commit_result, commit_pc); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(4'd1, 5'(i + 1), 64'h1000 + 64'(4 * i));
            checks++; if (issue_trans_id !== 2'(i)) begin errors++; $display("FAIL fill_id%0d: got %0d want %0d", i, issue_trans_id, i); end
            tick();
        end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", issue_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        set_wb(0, 2'd0, 64'h9, 1'b0, 64'd0);
        tick();
        set_issue(4'd1, 5'd9, 64'h2000);
        commit_ack = 1;
        checks++; if (issue_ready !== 1'b0 || commit_valid !== 1'b1) begin errors++; $display("FAIL full_ack_ready: got ready=%0b cv=%0b want 0 1", issue_ready, commit_valid); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_ack_count: got %0d want 3", count); end
        checks++; if (issue_ready !== 1'b1 || issue_trans_id !== 2'd0) begin errors++; $display("FAIL full_wrap_tail: got ready=%0b id=%0d want 1 0", issue_ready, issue_trans_id); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(4'd1, 5'(i + 1), 64'h1000 + 64'(4 * i));
            tick();
        end
        set_wb(1, 2'd2, 64'h22, 1'b0, 64'd0);
        tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_id2_only: got %0b want 0", commit_valid); end
        set_wb(0, 2'd0, 64'h55, 1'b0, 64'd0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_same_cycle: got %0b want 0", commit_valid); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h55) begin errors++; $display("FAIL ooo_head0: got cv=%0b res=%0h want 1 55", commit_valid, commit_result); end
        checks++; if (commit_trans_id !== 2'd0 || commit_rd !== 5'd1 || commit_pc !== 64'h1000) begin errors++; $display("FAIL ooo_head0_fields: got id=%0d rd=%0d pc=%0h want 0 1 1000", commit_trans_id, commit_rd, commit_pc); end
        commit_ack = 1;
        tick();
        checks++; if (commit_valid !== 1'b0 || commit_trans_id !== 2'd1) begin errors++; $display("FAIL ooo_id1_blocks: got cv=%0b id=%0d want 0 1", commit_valid, commit_trans_id); end
        commit_ack = 1;
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ooo_ack_ignored: got %0d want 2", count); end
        set_wb(2, 2'd1, 64'h11, 1'b0, 64'd0);
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h11) begin errors++; $display("FAIL ooo_head1: got cv=%0b res=%0h want 1 11", commit_valid, commit_result); end
        commit_ack = 1;
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_trans_id !== 2'd2 || commit_result !== 64'h22) begin errors++; $display("FAIL ooo_head2: got cv=%0b id=%0d res=%0h want 1 2 22", commit_valid, commit_trans_id, commit_result); end
        commit_ack = 1;
        tick();
        checks++; if (count !== 3'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained: got cnt=%0d cv=%0b want 0 0", count, commit_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_issue(4'd0, 5'(i + 1), 64'h3000 + 64'(i));
            checks++; if (issue_trans_id !== 2'(i % 4)) begin errors++; $display("FAIL wrap_issue_id%0d: got %0d want %0d", i, issue_trans_id, i % 4); end
            tick();
            checks++; if (commit_valid !== 1'b1 || commit_trans_id !== 2'(i % 4)) begin errors++; $display("FAIL wrap_commit%0d: got cv=%0b id=%0d want 1 %0d", i, commit_valid, commit_trans_id, i % 4); end
            commit_ack = 1;
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", count); end
    endtask

    task automatic test_forward();
        do_reset();
        set_issue(4'd1, 5'd5, 64'h40); tick();
        set_issue(4'd1, 5'd5, 64'h44); tick();
        set_wb(0, 2'd0, 64'hA, 1'b0, 64'd0);
        tick();
        rs1 = 5'd5; rs2 = 5'd5;
        #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_fwd_valid !== 1'b0 || rs1_fwd !== 64'd0) begin errors++; $display("FAIL fwd_young_pending: got b=%0b v=%0b d=%0h want 1 0 0", rs1_busy, rs1_fwd_valid, rs1_fwd); end
        checks++; if (rs2_busy !== 1'b1 || rs2_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_rs2_pending: got b=%0b v=%0b want 1 0", rs2_busy, rs2_fwd_valid); end
        set_wb(1, 2'd1, 64'hB, 1'b0, 64'd0);
        #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_no_bypass: got b=%0b v=%0b want 1 0", rs1_busy, rs1_fwd_valid); end
        tick();
        checks++; if (rs1_busy !== 1'b0 || rs1_fwd_valid !== 1'b1 || rs1_fwd !== 64'hB) begin errors++; $display("FAIL fwd_youngest: got b=%0b v=%0b d=%0h want 0 1 b", rs1_busy, rs1_fwd_valid, rs1_fwd); end
        rs1 = 5'd0; rs2 = 5'd7;
        #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_fwd_valid !== 1'b0 || rs1_fwd !== 64'd0) begin errors++; $display("FAIL fwd_x0: got b=%0b v=%0b d=%0h want 0 0 0", rs1_busy, rs1_fwd_valid, rs1_fwd); end
        checks++; if (rs2_busy !== 1'b0 || rs2_fwd_valid !== 1'b0 || rs2_fwd !== 64'd0) begin errors++; $display("FAIL fwd_nomatch: got b=%0b v=%0b d=%0h want 0 0 0", rs2_busy, rs2_fwd_valid, rs2_fwd); end
        rs2 = 5'd0;
    endtask

    task automatic test_port_conflict_exception();
        do_reset();
        set_issue(4'd1, 5'd1, 64'h50); tick();
        set_issue(4'd1, 5'd2, 64'h54); tick();
        set_wb(1, 2'd0, 64'h7, 1'b0, 64'd0);
        set_wb(0, 2'd1, 64'h1, 1'b0, 64'd0);
        set_wb(2, 2'd1, 64'h2, 1'b0, 64'd0);
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h7) begin errors++; $display("FAIL conflict_head0: got cv=%0b res=%0h want 1 7", commit_valid, commit_result); end
        commit_ack = 1;
        tick();
        checks++; if (commit_trans_id !== 2'd1 || commit_result !== 64'h2) begin errors++; $display("FAIL conflict_high_port: got id=%0d res=%0h want 1 2", commit_trans_id, commit_result); end
        commit_ack = 1;
        tick();
        set_issue(4'd1, 5'd3, 64'h58); tick();
        set_wb(0, 2'd2, 64'h33, 1'b1, 64'd2);
        tick();
        rs1 = 5'd3;
        #1;
        checks++; if (commit_valid !== 1'b1 || commit_ex_valid !== 1'b1 || commit_ex_cause !== 64'd2) begin errors++; $display("FAIL exc_commit: got cv=%0b ex=%0b cause=%0h want 1 1 2", commit_valid, commit_ex_valid, commit_ex_cause); end
        checks++; if (rs1_fwd_valid !== 1'b0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL exc_no_fwd: got v=%0b b=%0b want 0 0", rs1_fwd_valid, rs1_busy); end
        rs1 = 5'd0;
        set_wb(0, 2'd3, 64'hEE, 1'b0, 64'd0);
        tick();
        checks++; if (count !== 3'd1 || commit_trans_id !== 2'd2) begin errors++; $display("FAIL wb_not_busy: got cnt=%0d id=%0d want 1 2", count, commit_trans_id); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(4'd1, 5'(i + 1), 64'h60 + 64'(i)); tick();
        end
        set_wb(0, 2'd0, 64'h1, 1'b0, 64'd0);
        tick();
        flush = 1;
        set_issue(4'd1, 5'd9, 64'h70);
        set_wb(1, 2'd1, 64'h2, 1'b0, 64'd0);
        commit_ack = 1;
        tick();
        rs1 = 5'd1;
        #1;
        checks++; if (count !== 3'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got cnt=%0d cv=%0b want 0 0", count, commit_valid); end
        checks++; if (rs1_busy !== 1'b0 || rs1_fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_lookup: got b=%0b v=%0b want 0 0", rs1_busy, rs1_fwd_valid); end
        rs1 = 5'd0;
        set_issue(4'd0, 5'd4, 64'h80);
        checks++; if (issue_trans_id !== 2'd0 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_next_id: got id=%0d rdy=%0b want 0 1", issue_trans_id, issue_ready); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_trans_id !== 2'd0 || count !== 3'd1) begin errors++; $display("FAIL flush_reissue: got cv=%0b id=%0d cnt=%0d want 1 0 1", commit_valid, commit_trans_id, count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_issue(4'd1, 5'd1, 64'h90); tick();
        set_issue(4'd1, 5'd2, 64'h94); tick();
        set_wb(0, 2'd0, 64'h5, 1'b0, 64'd0);
        tick();
        rs1 = 5'd2;
        #1;
        checks++; if (commit_valid !== 1'b1 || rs1_busy !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL pre_reset: got cv=%0b b=%0b cnt=%0d want 1 1 2", commit_valid, rs1_busy, count); end
        rst = 1;
        #1;
        checks++; if (commit_valid !== 1'b0 || rs1_busy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL async_reset: got cv=%0b b=%0b cnt=%0d want 0 0 0", commit_valid, rs1_busy, count); end
        checks++; if (commit_result !== 64'd0 || commit_pc !== 64'd0 || issue_trans_id !== 2'd0 || issue_ready !== 1'b1) begin errors++; $display("FAIL async_reset_data: got res=%0h pc=%0h id=%0d rdy=%0b want 0 0 0 1", commit_result, commit_pc, issue_trans_id, issue_ready); end
        @(posedge clk);
        #1;
        rst = 0;
        rs1 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_wrap();
        test_forward();
        test_port_conflict_exception();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Parametrised in-order-issue / out-of-order-completion scoreboard.
- Sits between the ID stage (issue), the functional units (NR_WB_PORTS writeback ports) and the commit stage.
- Tracks up to NR_ENTRIES in-flight instructions and provides operand forwarding and busy lookup for two source registers.
- Successor of the fixed 4-entry / 3-port scoreboard: depth, writeback port count and transaction-ID width are generic, and flush and forwarding are added.

Parameters:
- NR_ENTRIES, 8, scoreboard depth; power of two, >=2
- NR_WB_PORTS, 3, number of writeback ports, >=1
- TRANS_ID_BITS, $clog2(NR_ENTRIES), derived localparam; not overridable

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  synchronous flush of all entries
- issue_valid_i  in  1  decoded instruction valid
- issue_ready_o  out  1  scoreboard can accept an instruction
- issue_pc_i  in  64  instruction PC
- issue_fu_i  in  4  fu_t target unit
- issue_rd_i  in  5  destination register
- issue_trans_id_o  out  TRANS_ID_BITS  ID assigned to the current issue
- wb_valid_i  in  NR_WB_PORTS  per-port writeback valid
- wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  per-port target entry
- wb_result_i  in  NR_WB_PORTS*64  per-port result
- wb_ex_valid_i  in  NR_WB_PORTS  per-port exception flag
- wb_ex_cause_i  in  NR_WB_PORTS*64  per-port exception cause
- commit_valid_o  out  1  oldest entry complete
- commit_ack_i  in  1  commit stage retires the oldest entry
- commit_trans_id_o  out  TRANS_ID_BITS  ID of the oldest entry
- commit_pc_o  out  64  PC of the oldest entry
- commit_rd_o  out  5  rd of the oldest entry
- commit_result_o  out  64  result of the oldest entry
- commit_ex_valid_o  out  1  oldest entry carries an exception
- commit_ex_cause_o  out  64  exception cause of the oldest entry
- rs1_i, rs2_i  in  5 each  source registers to look up
- rs1_busy_o, rs2_busy_o  out  1 each  pending producer, result not yet written
- rs1_fwd_valid_o, rs2_fwd_valid_o  out  1 each  forwardable result available
- rs1_fwd_o, rs2_fwd_o  out  64 each  forwarded value
- count_o  out  TRANS_ID_BITS+1  occupied entries

Behaviour:
- Storage: circular buffer of NR_ENTRIES; per entry busy, done, pc, fu, rd, result, ex_valid, ex_cause.
- Pointers: head (commit), tail (issue), count. Pointers wrap modulo NR_ENTRIES.
- Reset (async, rst_i=1): all entry fields 0, head=tail=count=0.
  - Outputs during/after reset: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, all commit_* data 0, all busy/fwd outputs 0, count_o=0.
- Issue:
  - issue_ready_o = (count < NR_ENTRIES); it does not see a same-cycle commit, so when full it stays 0 even if commit_ack_i=1.
  - Issue is accepted when issue_valid_i && issue_ready_o.
  - On accept, entry[tail] gets busy=1, done=0, ex_valid=0, result=0; tail is then incremented.
  - issue_trans_id_o = tail, combinational.
  - issue_fu_i==NONE: entry is written with done=1 (no writeback expected).
- Writeback:
  - Each port p with wb_valid_i[p] sets done=1 and writes result, ex_valid and ex_cause into entry wb_trans_id_i[p], taking effect at the next edge.
  - Target entry not busy: the write is ignored.
  - Two ports hitting the same ID in one cycle: the highest port index wins.
- Commit:
  - commit_valid_o = entry[head].busy && entry[head].done.
  - commit_* outputs show entry[head] combinationally.
  - commit_ack_i && commit_valid_o: entry[head].busy=0 and head is incremented.
  - commit_ack_i while commit_valid_o=0: ignored.
- Latency:
  - Writeback at edge N makes commit_valid_o=1 after edge N, if the entry is at head.
  - An fu NONE instruction issued at edge N is committable after edge N.
- Count: issue and commit in the same cycle leave count unchanged; count never exceeds NR_ENTRIES and never underflows.
- Flush (highest priority after reset):
  - Clears every busy bit and sets head=tail=count=0 at the edge.
  - Issue, writeback and commit_ack in the flush cycle are all ignored.
- Forwarding (combinational, registered state only; same-cycle writebacks are not bypassed):
  - rsX_i==0: all rsX outputs 0.
  - Otherwise select the youngest busy entry (nearest tail) with rd==rsX_i.
  - Selected entry done && !ex_valid: fwd_valid=1, fwd=result, busy=0.
  - Selected entry not done: busy=1, fwd_valid=0.
  - Selected entry done with an exception, or no matching entry: all rsX outputs 0.

Test Plan:
- Reset then idle -> issue_ready_o=1, count_o=0, commit_valid_o=0; assert rst_i mid-traffic -> all outputs return to 0 asynchronously.
- NR_ENTRIES=4: issue 4 ALU instructions (rd=1..4) -> IDs 0,1,2,3; issue_ready_o=0, count_o=4; commit_ack_i=1 with issue_valid_i=1 -> the issue is not accepted that cycle.
- Out-of-order writeback: wb ID2 then ID0 (result 0x55) -> commit_valid_o rises only after ID0, commit_result_o=0x55; after ack, ID1 still blocks commit; wrap test: 6 issue/commit pairs -> IDs 0,1,2,3,0,1.
- Forwarding: issue rd=5 twice (IDs 0,1); wb ID0 result 0xA -> rs1_i=5 gives busy=1, fwd_valid=0 (youngest is ID1 pending); wb ID1 result 0xB -> fwd_valid=1, fwd=0xB; rs1_i=0 -> all 0.
- Port conflict / exception: ports 0 and 2 write ID1 with 0x1 and 0x2 in the same cycle -> commit_result_o=0x2; wb ex_valid=1, cause=ILLEGAL_INSTR (2) -> commit_ex_valid_o=1, commit_ex_cause_o=2, rs lookup gives fwd_valid=0.
- Flush with 3 busy entries plus a simultaneous issue and writeback -> count_o=0, commit_valid_o=0, next issue gets ID 0.
